parity_frame_receiver: RTL and testbench

Receiving end of the parity-protected data channel: recovers 8-bit bytes from a serial line carrying start bit, eight data bits LSB first, even-parity bit and stop bit. It oversamples the line, samples each bit at mid-cell, checks parity and framing, and presents each byte with a one-cycle valid strobe and error flags. It sits downstream of the channel transmitter and feeds the link error statistics.

---
 rtl/rx_frame_pkg.sv | 21 ++
 rtl/bit_sync_edge.sv | 35 +++
 rtl/parity_frame_receiver.sv | 164 ++++++++++++++++
 tb/tb_parity_frame_receiver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// rtl/rx_frame_pkg.sv - shared types, frame constants and parity helper for the frame receiver
package rx_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // True when the data byte plus its parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] data,
                                          input logic                 par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/bit_sync_edge.sv
// rtl/bit_sync_edge.sv - two-flop line synchronizer with falling-edge detector
module bit_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic fall_o
);

  logic       s1_q;
  logic       s2_q;
  logic       prev_q;
  logic [1:0] prime_q;

  // prev_q only tracks the line once the reset value of the synchronizer has
  // been flushed out, so a line already low at reset release never looks like
  // a high->low transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      s1_q    <= din_i;
      s2_q    <= s1_q;
      prime_q <= {prime_q[0], 1'b1};
      prev_q  <= prime_q[1] ? s2_q : 1'b0;
    end
  end

  assign level_o = s2_q;
  assign fall_o  = prev_q & ~s2_q;

endmodule

// File: rtl/parity_frame_receiver.sv
// rtl/parity_frame_receiver.sv - serial frame receiver with even-parity and stop-bit checking
module parity_frame_receiver
  import rx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
  // Half a cell measured from the detector's edge; two of those cycles are
  // already spent in synchronizing and leaving IDLE.
  localparam logic [CNT_W-1:0] START_WAIT =
      CNT_W'((CLKS_PER_BIT / 2) >= 2 ? (CLKS_PER_BIT / 2) - 2 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  logic line_level;
  logic line_fall;

  bit_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .din_i   (rx_serial),
    .level_o (line_level),
    .fall_o  (line_fall)
  );

  rx_state_e                state_q,   state_d;
  logic [CNT_W-1:0]         cnt_q,     cnt_d;
  logic [IDX_W-1:0]         idx_q,     idx_d;
  logic [DATA_BITS-1:0]     shift_q,   shift_d;
  logic                     par_q,     par_d;
  logic                     stop_q,    stop_d;
  logic [7:0]               data_q,    data_d;
  logic                     perr_q,    perr_d;
  logic                     ferr_q,    ferr_d;
  logic                     valid_q,   valid_d;
  logic [ERR_CNT_W-1:0]     err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b1;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stop_d    = stop_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (line_fall) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == START_WAIT) begin
          cnt_d   = '0;
          state_d = line_level ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {line_level, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = line_level;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Sample at the cell centre, then deliver on the following cycle.
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          data_d  = shift_q;
          perr_d  = ~even_parity_ok(shift_q, par_q);
          ferr_d  = ~stop_q;
          valid_d = 1'b1;
          state_d = IDLE;
          if ((perr_d | ferr_d) && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == CNT_LAST) begin
            stop_d = line_level;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign error_count   = err_cnt_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb/tb_parity_frame_receiver.sv - scoreboard bench for parity_frame_receiver
module tb_parity_frame_receiver;

  localparam int C   = 4;
  localparam int LAT = 3 + C / 2 + 10 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;

  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;
  logic [7:0] ec_a;
  logic [1:0] ec_b;

  parity_frame_receiver #(.CLKS_PER_BIT(C), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_data(data_a), .rx_valid(valid_a),
    .parity_error(perr_a), .framing_error(ferr_a), .error_count(ec_a), .busy(busy_a)
  );

  parity_frame_receiver #(.CLKS_PER_BIT(C), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .rx_serial(rx_serial), .rx_data(data_b), .rx_valid(valid_b),
    .parity_error(perr_b), .framing_error(ferr_b), .error_count(ec_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cnt8;
    int         cnt2;
    int         due;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int nerr  = 0;

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a !== valid_b) check("valid_a_vs_b", {31'd0, valid_b}, {31'd0, valid_a});
      if (valid_a === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {24'd0, data_a}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_cycle", cyc, e.due);
          check("rx_data", {24'd0, data_a}, {24'd0, e.data});
          check("rx_data_w2", {24'd0, data_b}, {24'd0, e.data});
          check("parity_error", {31'd0, perr_a}, {31'd0, e.perr});
          check("framing_error", {31'd0, ferr_a}, {31'd0, e.ferr});
          check("busy_at_strobe", {31'd0, busy_a}, 32'd0);
          check("error_count_w8", {24'd0, ec_a}, e.cnt8);
          check("error_count_w2", {30'd0, ec_b}, e.cnt2);
        end
      end
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_serial = f[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic serr);
    logic  p;
    exp_t  e;
    p = (^d) ^ pflip;
    if (pflip || serr) nerr++;
    e.data = d;
    e.perr = pflip;
    e.ferr = serr;
    e.cnt8 = sat(nerr, 255);
    e.cnt2 = sat(nerr, 3);
    e.due  = cyc + LAT;
    q.push_back(e);
    send_bits({~serr, p, d, 1'b0}, 11);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, {24'd0, data_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, "_perr"}, {31'd0, perr_a}, 32'd0);
    check({tag, "_ferr"}, {31'd0, ferr_a}, 32'd0);
    check({tag, "_count"}, {24'd0, ec_a}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_a | busy_b}, 32'd0);
  endtask

  initial begin
    int   bc;
    logic prev_serr;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    idle(6);

    send_frame(8'hAA, 1'b0, 1'b0);
    idle(3);
    send_frame(8'hCC, 1'b1, 1'b0);
    idle(3);
    send_frame(8'hF0, 1'b0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    idle(4);

    // Single-cycle low glitch on an idle line.
    rx_serial = 1'b0;
    @(posedge clk);
    #1;
    rx_serial = 1'b1;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy_a) bc++;
    end
    @(posedge clk);
    #1;
    check("glitch_busy_cycles", bc, 1);
    check("glitch_count", {24'd0, ec_a}, sat(nerr, 255));

    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    idle(2);
    check("queue_before_reset", q.size(), 0);

    // Reset in the middle of a frame.
    send_bits({1'b1, ^8'h1C, 8'h1C, 1'b0}, 5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nerr = 0;
    check_reset_values("midframe");
    idle(60);

    // Line already low when reset releases.
    rx_serial = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("low_release_busy", {31'd0, busy_a}, 32'd0);
    idle(4);

    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    idle(3);

    prev_serr = 1'b0;
    for (int i = 0; i < 25; i++) begin
      int   gap;
      logic pf, se;
      gap = $urandom_range(0, 3);
      if (prev_serr && gap == 0) gap = 1;
      if (gap != 0) idle(gap);
      pf = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 7) == 0);
      send_frame(8'($urandom), pf, se);
      prev_serr = se;
    end
    idle(2);

    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
